// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_EARLY_OUT_EN to end a multiply once the remaining multiplier magnitude is zero.
module riscv_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       func3,
   input  logic [XLEN-1:0]  op_a,
   input  logic [XLEN-1:0]  op_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;
   logic [2:0] f3;
   logic neg, rneg;
   logic [CW-1:0] cnt;
   logic [2*XLEN-1:0] acc, mc, acc_n, prod;
   logic [XLEN-1:0] mp, mp_n, quo, rem, trial, res_n, fast_res, ma, mb;
   logic is_div, sa, sb, a_neg, b_neg, div_zero, ovf, mul_zero, fast, ge, last;
   assign in_ready = state == IDLE;
   assign busy     = state != IDLE;
   assign is_div   = func3[2];
   assign sa       = is_div ? !func3[0] : func3[1] ^ func3[0];
   assign sb       = is_div ? !func3[0] : func3[1:0] == 2'b01;
   assign a_neg    = sa & op_a[XLEN-1];
   assign b_neg    = sb & op_b[XLEN-1];
   assign ma       = a_neg ? -op_a : op_a;
   assign mb       = b_neg ? -op_b : op_b;
   assign div_zero = is_div && op_b == '0;
   assign ovf      = is_div && !func3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
   // The overflow quotient is the most-negative dividend itself
   assign fast_res = div_zero ? (func3[1] ? op_a : '1) : ovf ? (func3[1] ? '0 : op_a) : '0;
   assign fast     = div_zero | ovf | mul_zero;
   // Restoring divide: acc holds {partial remainder, dividend bits shifting into quotient}
   assign ge       = acc[2*XLEN-1:XLEN-1] >= {1'b0, mc[XLEN-1:0]};
   assign trial    = acc[2*XLEN-2:XLEN-1] - mc[XLEN-1:0];
   assign acc_n    = f3[2] ? (ge ? {trial, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0})
                           : acc + (mp[0] ? mc : '0);
   assign mp_n     = mp >> 1;
   assign prod     = neg ? -acc_n : acc_n;
   assign quo      = neg ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
   assign rem      = rneg ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
   assign res_n    = f3[2] ? (f3[1] ? rem : quo) : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`ifdef MULDIV_EARLY_OUT_EN
   assign mul_zero = !is_div && op_b == '0;
   assign last     = cnt == CW'(XLEN-1) || (!f3[2] && mp_n == '0);
`else
   assign mul_zero = 1'b0;
   assign last     = cnt == CW'(XLEN-1);
`endif
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         if (reset) begin
            result  <= '0;
            out_tag <= '0;
         end
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               f3        <= func3;
               out_tag   <= in_tag;
               neg       <= a_neg ^ b_neg;
               rneg      <= a_neg;
               cnt       <= '0;
               mp        <= mb;
               mc        <= {{XLEN{1'b0}}, is_div ? mb : ma};
               acc       <= is_div ? {{XLEN{1'b0}}, ma} : '0;
               result    <= fast_res;
               out_valid <= fast;
               state     <= fast ? DONE : CALC;
            end
            CALC: begin
               acc <= acc_n;
               mc  <= f3[2] ? mc : mc << 1;
               mp  <= mp_n;
               cnt <= cnt + 1'b1;
               if (last) begin
                  result    <= res_n;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
Iterative, parametrised RV32M/RV64M multiply-divide execution unit. It sits in EX beside the single-cycle ALU and accepts one M-extension operation at a time over a valid/ready handshake. It returns the XLEN-bit result with the destination register tag. The pipeline stalls on in_ready/out_valid and kills in-flight work with flush.

Parameters:
XLEN, 32, operand/result width (32 or 64).
TAG_W, 5, width of the destination-register tag carried through.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  kill in-flight operation (branch mispredict / exception)
in_valid  input  1  operation request
in_ready  output  1  unit can accept; high only in IDLE
func3  input  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value
op_b  input  XLEN  rs2 value
in_tag  input  TAG_W  rd index
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  XLEN  result value
out_tag  output  TAG_W  rd index of result
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, out_tag=0, busy=0, in_ready=1 on the cycle after reset deasserts. Reset mid-operation discards all work.
- FSM: IDLE -> CALC on accept (in_valid && in_ready && !flush). CALC -> DONE after the iteration counter hits XLEN-1. DONE -> IDLE on out_valid && out_ready. flush in any state -> IDLE next cycle with out_valid=0. flush takes priority over accept and over the output handshake.
- Accept: latch func3, in_tag, operand magnitudes and result sign. Signedness: MULH and DIV/REM treat both operands as signed. MULHSU treats op_a as signed and op_b as unsigned. MUL, MULHU, DIVU and REMU are unsigned.
- Multiply: radix-2 shift-add on magnitudes, one multiplier bit per CALC cycle, 2*XLEN-bit accumulator. MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits after two's-complement correction of the full 2*XLEN product.
- Divide: restoring radix-2, one quotient bit per CALC cycle. Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
- Fast path, decided at accept: divisor==0 gives quotient all-ones and remainder = op_a. Signed overflow (most-negative / -1) gives quotient = most-negative and remainder 0. Fast path goes IDLE -> DONE, skipping CALC; out_valid is high on the cycle after accept.
- Latency: accept at edge N. Normal op: out_valid high from cycle N+XLEN+1. out_valid, result and out_tag are registered and stay stable until the handshake completes.
- Throughput: one op per XLEN+2 cycles minimum. There is no accept in DONE, even when out_ready is high, so there is always one bubble cycle.
- in_valid while not in_ready: ignored; the requester holds its request.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: for multiply, CALC -> DONE as soon as the remaining unshifted multiplier magnitude is zero. Latency becomes 1 + index of the highest set bit of |multiplier| + 1 cycles, and the result is identical. A zero multiplier behaves like the fast path.
- Undefined: every non-fast-path op takes exactly XLEN CALC cycles. Divide is unaffected in both builds.

Test Plan:
- MUL 7 x 6, in_tag=5, out_ready=1 -> out_valid at cycle N+33 (XLEN=32), result=0x0000002A, out_tag=5; in_ready high again at N+34.
- MULH and MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> MULH=0x00000000, MULHU=0xFFFFFFFE, MUL=0x00000001. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REM 0x1234/0 -> 0x1234, both valid at N+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both valid at N+1.
- Backpressure: out_ready low for 5 cycles after out_valid -> result and out_tag held stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle.
- flush at CALC cycle 10, in_valid also high -> out_valid never asserts, no accept that cycle, in_ready=1 next cycle. A following MUL 3 x 3 returns 9. Separately, reset mid-CALC gives the same recovery.
